// File: rtl/decod_pkg.sv
// Shared types and helpers for the one-hot scan decoder.
package decod_pkg;

  localparam int N_MIN = 1;
  localparam int N_MAX = 6;
  localparam int W_MAX = 1 << N_MAX;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } decod_state_t;

  // Callers truncate the result to their own 2^N width.
  function automatic logic [W_MAX-1:0] onehot(input logic [N_MAX-1:0] sel);
    logic [W_MAX-1:0] r;
    r      = '0;
    r[sel] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/decod_next_sel.sv
// Circular priority search: the next enabled channel strictly after idx_i,
// wrapping modulo 2^N; the last candidate examined is idx_i itself.
module decod_next_sel
  import decod_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]    idx_i,
  input  logic [2**N-1:0] mask_i,
  output logic [N-1:0]    next_idx_o,
  output logic            wrap_o,
  output logic            none_o
);

  localparam int W = 1 << N;

  logic [N-1:0] cand;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise synthesis infers latches.
  always_comb begin
    next_idx_o = idx_i;
    none_o     = 1'b1;
    cand       = '0;
    // Walk from the farthest candidate to the nearest so the nearest hit wins.
    for (int k = W; k >= 1; k--) begin
      cand = idx_i + N'(k);
      if (mask_i[cand]) begin
        next_idx_o = cand;
        none_o     = 1'b0;
      end
    end
    wrap_o = !none_o && (next_idx_o <= idx_i);
  end

endmodule

// File: rtl/decodificador_varredura.sv
// N-to-2^N registered one-hot decoder with an optional prescaled scan mode.
// Define DECOD_SCAN_EN to build the SCAN state; otherwise mode=1 acts as direct.
module decodificador_varredura
  import decod_pkg::*;
#(
  parameter int N   = 3,
  parameter int DIV = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    in,
  input  logic            enable,
  input  logic            mode,
  input  logic [2**N-1:0] mask,
  output logic [2**N-1:0] out,
  output logic [N-1:0]    idx,
  output logic            wrap
);

  localparam int W  = 1 << N;
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] out_q;
  logic [N-1:0] idx_q;
  logic         wrap_q;
  decod_state_t state_d;

  assign out  = out_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

`ifdef DECOD_SCAN_EN

  decod_state_t state_q;
  logic [PW-1:0] presc_q;
  logic          last_direct_q;
  logic [N-1:0]  next_idx;
  logic          next_wrap;
  logic          next_none;
  logic          step;
  logic          scan_entry;

  decod_next_sel #(.N(N)) u_next_sel (
    .idx_i      (idx_q),
    .mask_i     (mask),
    .next_idx_o (next_idx),
    .wrap_o     (next_wrap),
    .none_o     (next_none)
  );

  always_comb begin
    state_d = ST_SCAN;
    if (!enable)    state_d = ST_OFF;
    else if (!mode) state_d = ST_DIRECT;
  end

  assign step = (presc_q == PW'(DIV - 1));
  // A scan restarts from `in` unless it is resuming after a pause.
  assign scan_entry = (state_q == ST_DIRECT) || ((state_q == ST_OFF) && last_direct_q);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_OFF;
      last_direct_q <= 1'b1;
      presc_q       <= '0;
      out_q         <= '0;
      idx_q         <= '0;
      wrap_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_d)
        ST_DIRECT: begin
          out_q         <= W'(onehot(N_MAX'(in)));
          idx_q         <= in;
          presc_q       <= '0;
          wrap_q        <= 1'b0;
          last_direct_q <= 1'b1;
        end
        ST_SCAN: begin
          last_direct_q <= 1'b0;
          if (scan_entry) begin
            out_q   <= W'(onehot(N_MAX'(in))) & mask;
            idx_q   <= in;
            presc_q <= '0;
            wrap_q  <= 1'b0;
          end else begin
            out_q <= W'(onehot(N_MAX'(idx_q))) & mask;
            if (step) begin
              presc_q <= '0;
              wrap_q  <= next_wrap;
              if (!next_none) idx_q <= next_idx;
            end else begin
              presc_q <= presc_q + PW'(1);
              wrap_q  <= 1'b0;
            end
          end
        end
        default: begin
          // OFF: idx and the prescaler hold so a paused scan can resume.
          out_q  <= '0;
          wrap_q <= 1'b0;
        end
      endcase
    end
  end

`else

  logic unused_scan_inputs;
  assign unused_scan_inputs = ^{mode, mask};

  always_comb begin
    state_d = ST_DIRECT;
    if (!enable) state_d = ST_OFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      idx_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (state_d == ST_DIRECT) begin
        out_q <= W'(onehot(N_MAX'(in)));
        idx_q <= in;
      end else begin
        out_q <= '0;
      end
    end
  end

`endif

endmodule

// File: tb/tb_decodificador_varredura.sv
// Directed bench for decodificador_varredura: two instances (DIV=2, DIV=4) share stimulus.
module tb_decodificador_varredura;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] in;
  logic       enable;
  logic       mode;
  logic [7:0] mask;
  logic [7:0] out2, out4;
  logic [2:0] idx2, idx4;
  logic       wrap2, wrap4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decodificador_varredura #(.N(3), .DIV(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in(in), .enable(enable), .mode(mode),
    .mask(mask), .out(out2), .idx(idx2), .wrap(wrap2)
  );

  decodificador_varredura #(.N(3), .DIV(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in(in), .enable(enable), .mode(mode),
    .mask(mask), .out(out4), .idx(idx4), .wrap(wrap4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; enable = 1'b0; mode = 1'b0; in = 3'd0; mask = 8'h00;
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (out2 !== 8'h00) begin n_err++; $display("FAIL reset_out2: got %h want 00", out2); end
    n_cmp++; if (idx2 !== 3'd0) begin n_err++; $display("FAIL reset_idx2: got %0d want 0", idx2); end
    n_cmp++; if (wrap2 !== 1'b0) begin n_err++; $display("FAIL reset_wrap2: got %b want 0", wrap2); end
    n_cmp++; if (out4 !== 8'h00) begin n_err++; $display("FAIL reset_out4: got %h want 00", out4); end
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_direct();
    logic [7:0] exp;
    enable = 1'b1; mode = 1'b0; mask = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      in = 3'(i);
      if (i > 0) begin
        exp = 8'h01 << (i - 1);
        n_cmp++; if (out2 !== exp) begin n_err++; $display("FAIL direct_latency[%0d]: got %h want %h", i, out2, exp); end
      end
      tick();
      exp = 8'h01 << i;
      n_cmp++; if (out2 !== exp) begin n_err++; $display("FAIL direct_out[%0d]: got %h want %h", i, out2, exp); end
      n_cmp++; if (idx2 !== 3'(i)) begin n_err++; $display("FAIL direct_idx[%0d]: got %0d want %0d", i, idx2, i); end
    end
  endtask

  task automatic test_enable_toggle();
    in = 3'd3; tick();
    n_cmp++; if (out2 !== 8'h08) begin n_err++; $display("FAIL en_on_out: got %h want 08", out2); end
    enable = 1'b0; tick();
    n_cmp++; if (out2 !== 8'h00) begin n_err++; $display("FAIL en_off_out2: got %h want 00", out2); end
    n_cmp++; if (out4 !== 8'h00) begin n_err++; $display("FAIL en_off_out4: got %h want 00", out4); end
    n_cmp++; if (idx2 !== 3'd3) begin n_err++; $display("FAIL en_off_idx: got %0d want 3", idx2); end
    enable = 1'b1;
  endtask

`ifdef DECOD_SCAN_EN

  task automatic test_full_scan();
    int e_idx[8]  = '{6, 6, 7, 7, 0, 0, 1, 1};
    int e_out[8]  = '{'h40, 'h40, 'h40, 'h80, 'h80, 'h01, 'h01, 'h02};
    int e_wrap[8] = '{0, 0, 0, 0, 1, 0, 0, 0};
    in = 3'd6; mode = 1'b0; mask = 8'hFF; tick();
    mode = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_cmp++; if (idx2 !== 3'(e_idx[k])) begin n_err++; $display("FAIL full_idx[%0d]: got %0d want %0d", k, idx2, e_idx[k]); end
      n_cmp++; if (out2 !== 8'(e_out[k])) begin n_err++; $display("FAIL full_out[%0d]: got %h want %h", k, out2, 8'(e_out[k])); end
      n_cmp++; if (wrap2 !== 1'(e_wrap[k])) begin n_err++; $display("FAIL full_wrap[%0d]: got %b want %0d", k, wrap2, e_wrap[k]); end
    end
  endtask

  task automatic test_masked_scan();
    int e_idx[8]  = '{0, 0, 2, 2, 5, 5, 0, 0};
    int e_out[8]  = '{'h01, 'h01, 'h01, 'h04, 'h04, 'h20, 'h20, 'h01};
    int e_wrap[8] = '{0, 0, 0, 0, 0, 0, 1, 0};
    in = 3'd0; mode = 1'b0; tick();
    mode = 1'b1; mask = 8'b0010_0101;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_cmp++; if (idx2 !== 3'(e_idx[k])) begin n_err++; $display("FAIL mask_idx[%0d]: got %0d want %0d", k, idx2, e_idx[k]); end
      n_cmp++; if (out2 !== 8'(e_out[k])) begin n_err++; $display("FAIL mask_out[%0d]: got %h want %h", k, out2, 8'(e_out[k])); end
      n_cmp++; if (wrap2 !== 1'(e_wrap[k])) begin n_err++; $display("FAIL mask_wrap[%0d]: got %b want %0d", k, wrap2, e_wrap[k]); end
    end
  endtask

  task automatic test_edge_masks();
    logic w2, w4;
    // Empty mask: idx holds, nothing drives, no wrap.
    in = 3'd2; mode = 1'b0; mask = 8'hFF; tick();
    mode = 1'b1; mask = 8'h00;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_cmp++; if (idx2 !== 3'd2) begin n_err++; $display("FAIL zero_idx[%0d]: got %0d want 2", k, idx2); end
      n_cmp++; if (out2 !== 8'h00) begin n_err++; $display("FAIL zero_out[%0d]: got %h want 00", k, out2); end
      n_cmp++; if (wrap2 !== 1'b0) begin n_err++; $display("FAIL zero_wrap[%0d]: got %b want 0", k, wrap2); end
    end
    // Single channel: idx stays 4, wrap every DIV cycles.
    in = 3'd4; mode = 1'b0; mask = 8'hFF; tick();
    mode = 1'b1; mask = 8'h10;
    for (int k = 0; k < 10; k++) begin
      tick();
      w4 = (k == 4) || (k == 8);
      w2 = (k > 0) && (k % 2 == 0);
      n_cmp++; if (idx4 !== 3'd4) begin n_err++; $display("FAIL single_idx4[%0d]: got %0d want 4", k, idx4); end
      n_cmp++; if (out4 !== 8'h10) begin n_err++; $display("FAIL single_out4[%0d]: got %h want 10", k, out4); end
      n_cmp++; if (wrap4 !== w4) begin n_err++; $display("FAIL single_wrap4[%0d]: got %b want %b", k, wrap4, w4); end
      n_cmp++; if (wrap2 !== w2) begin n_err++; $display("FAIL single_wrap2[%0d]: got %b want %b", k, wrap2, w2); end
    end
    // Pause for 5 cycles mid-period; the prescaler must resume from its held value.
    in = 3'd0; mode = 1'b0; mask = 8'hFF; tick();
    mode = 1'b1;
    tick(); tick(); tick();
    n_cmp++; if (idx4 !== 3'd0) begin n_err++; $display("FAIL pause_pre_idx4: got %0d want 0", idx4); end
    n_cmp++; if (idx2 !== 3'd1) begin n_err++; $display("FAIL pause_pre_idx2: got %0d want 1", idx2); end
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++; if (out4 !== 8'h00) begin n_err++; $display("FAIL pause_out4[%0d]: got %h want 00", k, out4); end
      n_cmp++; if (idx4 !== 3'd0) begin n_err++; $display("FAIL pause_idx4[%0d]: got %0d want 0", k, idx4); end
      n_cmp++; if (out2 !== 8'h00) begin n_err++; $display("FAIL pause_out2[%0d]: got %h want 00", k, out2); end
      n_cmp++; if (wrap2 !== 1'b0) begin n_err++; $display("FAIL pause_wrap2[%0d]: got %b want 0", k, wrap2); end
    end
    enable = 1'b1;
    tick();
    n_cmp++; if (idx4 !== 3'd0) begin n_err++; $display("FAIL resume1_idx4: got %0d want 0", idx4); end
    n_cmp++; if (out4 !== 8'h01) begin n_err++; $display("FAIL resume1_out4: got %h want 01", out4); end
    tick();
    n_cmp++; if (idx4 !== 3'd1) begin n_err++; $display("FAIL resume2_idx4: got %0d want 1", idx4); end
    n_cmp++; if (idx2 !== 3'd2) begin n_err++; $display("FAIL resume2_idx2: got %0d want 2", idx2); end
  endtask

`else

  task automatic test_scan_disabled();
    int vals[3] = '{1, 6, 4};
    logic [7:0] exp;
    mode = 1'b1; mask = 8'h05;
    for (int k = 0; k < 3; k++) begin
      in = 3'(vals[k]);
      tick();
      exp = 8'h01 << vals[k];
      n_cmp++; if (out2 !== exp) begin n_err++; $display("FAIL nosc_out[%0d]: got %h want %h", k, out2, exp); end
      n_cmp++; if (idx2 !== 3'(vals[k])) begin n_err++; $display("FAIL nosc_idx[%0d]: got %0d want %0d", k, idx2, vals[k]); end
      n_cmp++; if (wrap2 !== 1'b0) begin n_err++; $display("FAIL nosc_wrap[%0d]: got %b want 0", k, wrap2); end
    end
  endtask

`endif

  task automatic test_reset_mid_scan();
    enable = 1'b1; mode = 1'b0; mask = 8'hFF; in = 3'd5; tick();
    mode = 1'b1;
    tick(); tick();
    n_cmp++; if (idx4 !== 3'd5) begin n_err++; $display("FAIL rst_pre_idx4: got %0d want 5", idx4); end
    n_cmp++; if (out4 !== 8'h20) begin n_err++; $display("FAIL rst_pre_out4: got %h want 20", out4); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out4 !== 8'h00) begin n_err++; $display("FAIL rst_async_out4: got %h want 00", out4); end
    n_cmp++; if (idx4 !== 3'd0) begin n_err++; $display("FAIL rst_async_idx4: got %0d want 0", idx4); end
    n_cmp++; if (wrap4 !== 1'b0) begin n_err++; $display("FAIL rst_async_wrap4: got %b want 0", wrap4); end
    n_cmp++; if (idx2 !== 3'd0) begin n_err++; $display("FAIL rst_async_idx2: got %0d want 0", idx2); end
    tick();
    rst_n = 1'b1; mode = 1'b0; in = 3'd6;
    tick();
    n_cmp++; if (out2 !== 8'h40) begin n_err++; $display("FAIL rst_release_out: got %h want 40", out2); end
    n_cmp++; if (idx2 !== 3'd6) begin n_err++; $display("FAIL rst_release_idx: got %0d want 6", idx2); end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_enable_toggle();
`ifdef DECOD_SCAN_EN
    test_full_scan();
    test_masked_scan();
    test_edge_masks();
`else
    test_scan_disabled();
`endif
    test_reset_mid_scan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, limit 100000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
